ddr_read_arbiter: RTL and testbench

DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

---
 rtl/ddr_read_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_arbiter.sv
// Two-requester AXI4 read arbiter (weight / feature) with a single burst in flight.
// Define DDR_RD_ARB_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif

module ddr_read_arbiter #(
  parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] req0_addr,
  input  logic [7:0]                req0_len,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] req1_addr,
  input  logic [7:0]                req1_len,
  output logic                      req1_ready,
  output logic [MEM_DATA_WIDTH-1:0] rd_data,
  output logic                      rd0_valid,
  output logic                      rd1_valid,
  output logic                      rd_last,
  output logic                      len_err,
  output logic                      resp_err,
  output logic [MEM_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [7:0]                m00_axi_arlen,
  output logic [2:0]                m00_axi_arsize,
  output logic [1:0]                m00_axi_arburst,
  output logic                      m00_axi_arvalid,
  input  logic                      m00_axi_arready,
  input  logic [MEM_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                m00_axi_rresp,
  input  logic                      m00_axi_rlast,
  input  logic                      m00_axi_rvalid,
  output logic                      m00_axi_rready
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  arb_state_t                state_q, state_d;
  logic                      owner_q;
  logic [MEM_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                arlen_q;
  logic [8:0]                beat_cnt_q;
  logic                      len_err_q;
  logic                      resp_err_q;

  logic grant_any;
  logic grant_sel;  // 0 = requester 0 wins, 1 = requester 1 wins
  logic beat_acc;

  assign grant_any = req0_valid | req1_valid;
  assign beat_acc  = (state_q == ARB_DATA) & m00_axi_rvalid;

`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_comb begin
    grant_sel = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ARB_IDLE && grant_any) begin
      last_grant_q <= grant_sel;
    end
  end
`else
  assign grant_sel = ~req0_valid;
`endif

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant_any) state_d = ARB_ADDR;
      ARB_ADDR: if (m00_axi_arready) state_d = ARB_DATA;
      ARB_DATA: if (beat_acc && m00_axi_rlast) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Grant pulse is combinational so the requester sees ready in the grant cycle itself.
  always_comb begin
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    m00_axi_arvalid = (state_q == ARB_ADDR);
    m00_axi_rready  = (state_q == ARB_DATA);
    if (state_q == ARB_IDLE && rst_n && grant_any) begin
      req0_ready = ~grant_sel;
      req1_ready = grant_sel;
    end
    rd0_valid = beat_acc & ~owner_q;
    rd1_valid = beat_acc & owner_q;
    rd_last   = beat_acc & m00_axi_rlast;
  end

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= 8'd0;
      beat_cnt_q <= 9'd0;
      len_err_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (state_q == ARB_IDLE && grant_any) begin
        owner_q  <= grant_sel;
        araddr_q <= grant_sel ? req1_addr : req0_addr;
        arlen_q  <= grant_sel ? req1_len : req0_len;
      end
      if (state_q == ARB_ADDR && m00_axi_arready) begin
        beat_cnt_q <= 9'd0;
      end
      if (beat_acc) begin
        if (beat_cnt_q != 9'h1FF) begin
          beat_cnt_q <= beat_cnt_q + 9'd1;
        end
        if (m00_axi_rresp != 2'b00) begin
          resp_err_q <= 1'b1;
        end
        // Over-long burst is flagged on every extra beat; we still wait for rlast.
        if (beat_cnt_q > {1'b0, arlen_q}) begin
          len_err_q <= 1'b1;
        end
        if (m00_axi_rlast && beat_cnt_q != {1'b0, arlen_q}) begin
          len_err_q <= 1'b1;
        end
      end
    end
  end

  assign m00_axi_araddr  = araddr_q;
  assign m00_axi_arlen   = arlen_q;
  assign m00_axi_arsize  = 3'b110;
  assign m00_axi_arburst = 2'b01;
  assign rd_data         = m00_axi_rdata;
  assign len_err         = len_err_q;
  assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Self-checking bench for ddr_read_arbiter: transaction-level model plus AXI slave stub,
// directed scenarios followed by randomized traffic.

module tb_ddr_read_arbiter;
  localparam int AW = 32;
  localparam int DW = 512;

  logic          system_clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [7:0]    req0_len, req1_len;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] rd_data;
  logic          rd0_valid, rd1_valid, rd_last, len_err, resp_err;
  logic [AW-1:0] m00_axi_araddr;
  logic [7:0]    m00_axi_arlen;
  logic [2:0]    m00_axi_arsize;
  logic [1:0]    m00_axi_arburst;
  logic          m00_axi_arvalid, m00_axi_arready;
  logic [DW-1:0] m00_axi_rdata;
  logic [1:0]    m00_axi_rresp;
  logic          m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;

  always #5 system_clk = ~system_clk;

  ddr_read_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
    .system_clk(system_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rd_data(rd_data), .rd0_valid(rd0_valid), .rd1_valid(rd1_valid), .rd_last(rd_last),
    .len_err(len_err), .resp_err(resp_err),
    .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
    .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
    .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
    .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid),
    .m00_axi_rready(m00_axi_rready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Transaction-level model of the arbiter
  bit            m_busy, m_arph, m_owner, m_len_err, m_resp_err;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  int            m_beats;
  int            m_done = 0;
`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
  int            m_last_grant;
`endif
  int            e_win;
  bit            e_arvalid, e_rready, e_acc;

  // Slave stub state and knobs
  int s_ar_cnt, s_plan, s_sent;
  int k_ar_delay = 1, k_pct = 100, k_plan = 0, k_err_beat = -1;
  bit k_rand = 0;

  // Requester intent
  bit            rv[2];
  logic [AW-1:0] ra[2];
  logic [7:0]    rl[2];
  bit            rq_hold[2];
  bit            rq_auto = 0;

  // Observations of DUT behaviour used by the directed checks
  int            o_ready[2], o_rd[2], o_last, o_last_at;
  int            grants[$];
  logic [AW-1:0] cap_araddr;
  logic [7:0]    cap_arlen;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(bit v0, bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
    return 1 - m_last_grant;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_arph = 0; m_owner = 0; m_len_err = 0; m_resp_err = 0;
    m_araddr = '0; m_arlen = 8'd0; m_beats = 0;
`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
    m_last_grant = 1;
`endif
    s_ar_cnt = 0; s_plan = 0; s_sent = 0;
  endtask

  task automatic slave_drive();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    m00_axi_rdata = d;
    if (m_busy && m_arph)
      m00_axi_arready = (k_ar_delay < 0) ? 1'($urandom_range(0, 1)) : (s_ar_cnt >= k_ar_delay);
    else
      m00_axi_arready = 1'($urandom_range(0, 1));
    if (m_busy && !m_arph && s_sent < s_plan) begin
      m00_axi_rvalid = ($urandom_range(0, 99) < k_pct);
      m00_axi_rlast  = (s_sent == s_plan - 1);
      if (s_sent == k_err_beat) m00_axi_rresp = 2'b10;
      else if (k_rand && $urandom_range(0, 15) == 0) m00_axi_rresp = 2'($urandom_range(1, 3));
      else m00_axi_rresp = 2'b00;
    end else begin
      // Bus noise that must be ignored outside the data phase
      m00_axi_rvalid = ($urandom_range(0, 3) == 0);
      m00_axi_rlast  = 1'($urandom_range(0, 1));
      m00_axi_rresp  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drive_req();
    if (!rq_auto) return;
    for (int n = 0; n < 2; n++) begin
      if (!rv[n]) begin
        if ($urandom_range(0, 3) == 0) begin
          rv[n] = 1; ra[n] = $urandom; rl[n] = 8'($urandom_range(0, 7));
        end
      end else if (m_busy && $urandom_range(0, 15) == 0) begin
        rv[n] = 0;
      end
    end
  endtask

  task automatic compare();
    bit ex_rd0, ex_rd1;
    ex_rd0 = e_acc && !m_owner;
    ex_rd1 = e_acc && m_owner;
    chk("req0_ready", req0_ready, e_win == 0);
    chk("req1_ready", req1_ready, e_win == 1);
    chk("arvalid", m00_axi_arvalid, e_arvalid);
    chk("rready", m00_axi_rready, e_rready);
    chk("araddr", m00_axi_araddr, m_araddr);
    chk("arlen", m00_axi_arlen, m_arlen);
    chk("arsize", m00_axi_arsize, 3'b110);
    chk("arburst", m00_axi_arburst, 2'b01);
    chk("rd0_valid", rd0_valid, ex_rd0);
    chk("rd1_valid", rd1_valid, ex_rd1);
    chk("rd_last", rd_last, e_acc && m00_axi_rlast);
    chk("len_err", len_err, m_len_err);
    chk("resp_err", resp_err, m_resp_err);
    n_checks++;
    if (rd_data !== m00_axi_rdata) begin
      n_errors++;
      $display("FAIL rd_data cycle %0d actual=%0h required=%0h", cyc, rd_data, m00_axi_rdata);
    end
    if (req0_ready) begin o_ready[0]++; grants.push_back(0); end
    if (req1_ready) begin o_ready[1]++; grants.push_back(1); end
    if (rd0_valid) o_rd[0]++;
    if (rd1_valid) o_rd[1]++;
    if (rd_last) begin o_last++; o_last_at = o_rd[0] + o_rd[1]; end
    if (m00_axi_arvalid) begin cap_araddr = m00_axi_araddr; cap_arlen = m00_axi_arlen; end
  endtask

  task automatic advance();
    if (rst_n !== 1'b1) begin
      model_reset();
    end else if (e_win >= 0) begin
      m_busy = 1; m_arph = 1; m_owner = (e_win == 1);
      m_araddr = ra[e_win]; m_arlen = rl[e_win];
`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
      m_last_grant = e_win;
`endif
      s_ar_cnt = 0;
      if (!rq_hold[e_win]) rv[e_win] = 0;
    end else if (e_arvalid) begin
      if (m00_axi_arready) begin
        m_arph = 0; m_beats = 0; s_sent = 0;
        if (k_plan > 0) s_plan = k_plan;
        else if (k_rand && $urandom_range(0, 7) == 0) s_plan = $urandom_range(1, int'(m_arlen) + 3);
        else s_plan = int'(m_arlen) + 1;
      end else begin
        s_ar_cnt++;
      end
    end else if (e_acc) begin
      if (m00_axi_rresp != 2'b00) m_resp_err = 1;
      if (m_beats > int'(m_arlen)) m_len_err = 1;
      if (m00_axi_rlast) begin
        if (m_beats != int'(m_arlen)) m_len_err = 1;
        m_busy = 0;
        m_done++;
      end
      if (m_beats < 511) m_beats++;
      s_sent++;
    end
  endtask

  task automatic step();
    req0_valid = rv[0]; req0_addr = ra[0]; req0_len = rl[0];
    req1_valid = rv[1]; req1_addr = ra[1]; req1_len = rl[1];
    e_win     = (!m_busy && rst_n === 1'b1) ? pick(rv[0], rv[1]) : -1;
    e_arvalid = m_busy && m_arph;
    e_rready  = m_busy && !m_arph;
    e_acc     = e_rready && m00_axi_rvalid;
    @(negedge system_clk);
    compare();
    @(posedge system_clk);
    advance();
    #1;
    cyc++;
  endtask

  task automatic cycle();
    drive_req();
    slave_drive();
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_bursts(int n, int limit);
    int target = m_done + n;
    int c = 0;
    while (m_done < target && c < limit) begin
      cycle();
      c++;
    end
    chk("burst_timeout", m_done >= target, 1);
  endtask

  initial begin
    int base_rd0, base_rd1, base_last, base_rdy0, base_rd;
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin rv[n] = 0; ra[n] = '0; rl[n] = 8'd0; rq_hold[n] = 0; end
    m00_axi_arready = 0; m00_axi_rvalid = 0; m00_axi_rlast = 0; m00_axi_rresp = 0; m00_axi_rdata = '0;
    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0; req0_len = 0; req1_len = 0;
    model_reset();
    @(posedge system_clk);
    #1;
    repeat (3) cycle();

    // Reset state, literal
    chk("rst_arvalid", m00_axi_arvalid, 0);
    chk("rst_rready", m00_axi_rready, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_araddr", m00_axi_araddr, 0);
    chk("rst_arlen", m00_axi_arlen, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_arsize", m00_axi_arsize, 3'b110);
    chk("rst_arburst", m00_axi_arburst, 2'b01);
    rst_n = 1'b1;

    // Single 256-beat burst from requester 0
    k_ar_delay = 3; k_pct = 100;
    base_rd0 = o_rd[0]; base_rd1 = o_rd[1]; base_last = o_last; base_rdy0 = o_ready[0];
    base_rd = o_rd[0] + o_rd[1];
    rv[0] = 1; ra[0] = 32'h0800_0000; rl[0] = 8'd255; rq_hold[0] = 0;
    run_bursts(1, 2000);
    chk("A_ready0_pulses", o_ready[0] - base_rdy0, 1);
    chk("A_araddr", cap_araddr, 32'h0800_0000);
    chk("A_arlen", cap_arlen, 8'd255);
    chk("A_rd0_beats", o_rd[0] - base_rd0, 256);
    chk("A_rd1_beats", o_rd[1] - base_rd1, 0);
    chk("A_rd_last_count", o_last - base_last, 1);
    chk("A_rd_last_beat", o_last_at - base_rd, 256);

    // Contention, both held from reset with len 63
    k_ar_delay = 1;
    rv[0] = 1; ra[0] = 32'h0000_1000; rl[0] = 8'd63; rq_hold[0] = 1;
    rv[1] = 1; ra[1] = 32'h0000_2000; rl[1] = 8'd63; rq_hold[1] = 1;
    do_reset();
    grants.delete();
    run_bursts(4, 1000);
    chk("B_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
`ifdef DDR_RD_ARB_ROUND_ROBIN_EN
      chk("B_grant0", grants[0], 0);
      chk("B_grant1", grants[1], 1);
      chk("B_grant2", grants[2], 0);
      chk("B_grant3", grants[3], 1);
`else
      chk("B_grant0", grants[0], 0);
      chk("B_grant1", grants[1], 0);
      chk("B_grant2", grants[2], 0);
      chk("B_grant3", grants[3], 0);
`endif
    end
    rv[0] = 0; rq_hold[0] = 0;
    run_bursts(1, 500);
    chk("B_after_drop", (grants.size() >= 5) ? grants[4] : -1, 1);
    rv[1] = 0; rq_hold[1] = 0;
    cycle();

    // Short burst: rlast on beat 32 of 64
    do_reset();
    k_plan = 32;
    rv[0] = 1; ra[0] = 32'h0000_4000; rl[0] = 8'd63;
    run_bursts(1, 500);
    chk("C_len_err", len_err, 1);
    k_plan = 0;
    repeat (5) cycle();
    chk("C_len_err_hold", len_err, 1);
    chk("C_idle_arvalid", m00_axi_arvalid, 0);
    chk("C_idle_rready", m00_axi_rready, 0);

    // Error response on beat 5
    do_reset();
    chk("D_resp_err_clear", resp_err, 0);
    k_err_beat = 4;
    rv[1] = 1; ra[1] = 32'h0000_8000; rl[1] = 8'd15;
    run_bursts(1, 300);
    chk("D_resp_err_set", resp_err, 1);
    k_err_beat = -1;
    rv[0] = 1; ra[0] = 32'h0000_9000; rl[0] = 8'd7;
    run_bursts(1, 300);
    chk("D_resp_err_hold", resp_err, 1);
    do_reset();
    chk("D_resp_err_reset", resp_err, 0);

    // Reset during beat 10 of 64
    rv[0] = 1; ra[0] = 32'h0001_0000; rl[0] = 8'd63; rq_hold[0] = 1;
    rv[1] = 1; ra[1] = 32'h0002_0000; rl[1] = 8'd63; rq_hold[1] = 1;
    base_rd = o_rd[0] + o_rd[1];
    for (int c = 0; c < 500; c++) begin
      drive_req();
      slave_drive();
      if (m_busy && !m_arph && s_sent == 9 && m00_axi_rvalid) rst_n = 1'b0;
      step();
      if (rst_n == 1'b0) break;
    end
    chk("E_beats_before_reset", o_rd[0] + o_rd[1] - base_rd, 10);
    chk("E_rready", m00_axi_rready, 0);
    chk("E_arvalid", m00_axi_arvalid, 0);
    chk("E_ready0", req0_ready, 0);
    chk("E_ready1", req1_ready, 0);
    chk("E_rd0", rd0_valid, 0);
    chk("E_rd1", rd1_valid, 0);
    rst_n = 1'b1;
    grants.delete();
    run_bursts(1, 500);
    chk("E_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    rv[0] = 0; rv[1] = 0; rq_hold[0] = 0; rq_hold[1] = 0;

    // Randomized traffic
    rq_auto = 1; k_ar_delay = -1; k_pct = 60; k_plan = 0; k_err_beat = -1; k_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
